// File: rtl/magnitude_comp_seq.sv
// Sequential WIDTH-bit magnitude comparator: DIGIT bits per cycle, MSB chunk first, early exit.
// Optional macro MAGCOMP_SIGNED_MODE_EN adds a signed_mode input for two's-complement compares.
module magnitude_comp_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MAGCOMP_SIGNED_MODE_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("magnitude_comp_seq: WIDTH must be >= 2 and DIGIT must divide WIDTH");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  // Result encoding {gt, eq, lt}.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             done_q, done_d;
  logic [2:0]       res_q, res_d;

  logic [DIGIT-1:0] a_chunk;
  logic [DIGIT-1:0] b_chunk;
  logic [WIDTH-1:0] capture_mask;

`ifdef MAGCOMP_SIGNED_MODE_EN
  // Flipping the sign bit once at capture makes an unsigned compare of the
  // top chunk order two's-complement values correctly.
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};
  assign capture_mask = signed_mode ? SIGN_MASK : '0;
`else
  assign capture_mask = '0;
`endif

  assign a_chunk = DIGIT'(a_q >> (int'(idx_q) * DIGIT));
  assign b_chunk = DIGIT'(b_q >> (int'(idx_q) * DIGIT));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; combinational blocks use blocking ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      res_q   <= RES_NONE;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a ^ capture_mask;
          b_d     = b ^ capture_mask;
          idx_d   = IW'(N - 1);
          res_d   = RES_NONE;
          state_d = RUN;
        end
      end
      RUN: begin
        if (a_chunk > b_chunk) begin
          res_d   = RES_GT;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (a_chunk < b_chunk) begin
          res_d   = RES_LT;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == '0) begin
          res_d   = RES_EQ;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q == RUN);
    done         = done_q;
    {gt, eq, lt} = res_q;
  end

endmodule

// File: tb/tb_magnitude_comp_seq.sv
// Directed self-checking bench for magnitude_comp_seq: 8/2 main instance plus a 16-bit DIGIT sweep.
// Build with MAGCOMP_SIGNED_MODE_EN defined to also exercise the signed-mode vectors.
module tb_magnitude_comp_seq;

  localparam logic [2:0] R_NONE = 3'b000;
  localparam logic [2:0] R_GT   = 3'b100;
  localparam logic [2:0] R_EQ   = 3'b010;
  localparam logic [2:0] R_LT   = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // Main instance, WIDTH=8 DIGIT=2.
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       sm = 1'b0;
  logic       busy, done, gt, eq, lt;

  // Sweep instances, WIDTH=16, sharing stimulus.
  logic        start_s = 1'b0;
  logic [15:0] a_s = '0;
  logic [15:0] b_s = '0;
  logic        busy1, done1, gt1, eq1, lt1;
  logic        busy4, done4, gt4, eq4, lt4;
  logic        busy16, done16, gt16, eq16, lt16;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  magnitude_comp_seq #(.WIDTH(8), .DIGIT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef MAGCOMP_SIGNED_MODE_EN
    .signed_mode(sm),
`endif
    .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
  );

  magnitude_comp_seq #(.WIDTH(16), .DIGIT(1)) u_dut_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .a(a_s), .b(b_s),
`ifdef MAGCOMP_SIGNED_MODE_EN
    .signed_mode(1'b0),
`endif
    .busy(busy1), .done(done1), .gt(gt1), .eq(eq1), .lt(lt1)
  );

  magnitude_comp_seq #(.WIDTH(16), .DIGIT(4)) u_dut_d4 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .a(a_s), .b(b_s),
`ifdef MAGCOMP_SIGNED_MODE_EN
    .signed_mode(1'b0),
`endif
    .busy(busy4), .done(done4), .gt(gt4), .eq(eq4), .lt(lt4)
  );

  magnitude_comp_seq #(.WIDTH(16), .DIGIT(16)) u_dut_d16 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .a(a_s), .b(b_s),
`ifdef MAGCOMP_SIGNED_MODE_EN
    .signed_mode(1'b0),
`endif
    .busy(busy16), .done(done16), .gt(gt16), .eq(eq16), .lt(lt16)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Caller sits at a negedge. Pulses start, then returns at the negedge where
  // done is seen (or after the cycle budget expires, with lat = 20).
  task automatic run_cmp(input logic [7:0] av, input logic [7:0] bv, input logic smv,
                         output int lat, output logic [2:0] res,
                         output int busy_cycles, output logic zero_during);
    start = 1'b1;
    a     = av;
    b     = bv;
    sm    = smv;
    @(negedge clk);
    start       = 1'b0;
    lat         = 0;
    busy_cycles = 0;
    zero_during = 1'b1;
    while (!done && lat < 20) begin
      if (busy) busy_cycles++;
      if ({gt, eq, lt} != R_NONE) zero_during = 1'b0;
      @(negedge clk);
      lat++;
    end
    res = {gt, eq, lt};
  endtask

  // Expected latency for a WIDTH=16 compare at the given DIGIT.
  function automatic int exp_lat16(input logic [15:0] av, input logic [15:0] bv, input int dg);
    logic [15:0] x;
    int n;
    x = av ^ bv;
    n = 16 / dg;
    for (int i = 15; i >= 0; i--)
      if (x[i]) return n - (i / dg);
    return n;
  endfunction

  function automatic logic [2:0] exp_res16(input logic [15:0] av, input logic [15:0] bv);
    if (av > bv) return R_GT;
    if (av < bv) return R_LT;
    return R_EQ;
  endfunction

  task automatic run_sweep(input logic [15:0] av, input logic [15:0] bv, input string tag);
    int lat1, lat4, lat16;
    logic [2:0] r1, r4, r16;
    lat1 = -1; lat4 = -1; lat16 = -1;
    r1 = R_NONE; r4 = R_NONE; r16 = R_NONE;
    start_s = 1'b1;
    a_s     = av;
    b_s     = bv;
    @(negedge clk);
    start_s = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (done1  && lat1  < 0) begin lat1  = cyc; r1  = {gt1, eq1, lt1};    end
      if (done4  && lat4  < 0) begin lat4  = cyc; r4  = {gt4, eq4, lt4};    end
      if (done16 && lat16 < 0) begin lat16 = cyc; r16 = {gt16, eq16, lt16}; end
      if (lat1 > 0 && lat4 > 0 && lat16 > 0) break;
    end
    check({tag, " d1 res"},  int'(r1),  int'(exp_res16(av, bv)));
    check({tag, " d1 lat"},  lat1,      exp_lat16(av, bv, 1));
    check({tag, " d4 res"},  int'(r4),  int'(exp_res16(av, bv)));
    check({tag, " d4 lat"},  lat4,      exp_lat16(av, bv, 4));
    check({tag, " d16 res"}, int'(r16), int'(exp_res16(av, bv)));
    check({tag, " d16 lat"}, lat16,     exp_lat16(av, bv, 16));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, dones;
    logic [2:0] res;
    logic zd;

    // Reset state.
    #12;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset res",  int'({gt, eq, lt}), int'(R_NONE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // MSB chunk differs: 1-cycle compare.
    run_cmp(8'hA5, 8'h35, 1'b0, lat, res, bc, zd);
    check("msb lat",  lat, 1);
    check("msb res",  int'(res), int'(R_GT));
    check("msb busy", bc, 1);
    repeat (3) @(negedge clk);
    check("msb held", int'({gt, eq, lt}), int'(R_GT));
    check("msb done pulse", int'(done), 0);

    // LSB chunk differs.
    run_cmp(8'h12, 8'h13, 1'b0, lat, res, bc, zd);
    check("lsb lat",  lat, 4);
    check("lsb res",  int'(res), int'(R_LT));
    check("lsb zero", int'(zd), 1);
    check("lsb busy", bc, 4);
    @(negedge clk);

    // Equal operands.
    run_cmp(8'h5A, 8'h5A, 1'b0, lat, res, bc, zd);
    check("eq lat",  lat, 4);
    check("eq res",  int'(res), int'(R_EQ));
    check("eq zero", int'(zd), 1);

    // Back-to-back: start in the done cycle is accepted and clears results.
    run_cmp(8'h01, 8'h00, 1'b0, lat, res, bc, zd);
    check("b2b lat",  lat, 4);
    check("b2b res",  int'(res), int'(R_GT));
    check("b2b zero", int'(zd), 1);
    @(negedge clk);

    // start held through the run with operands changed mid-run.
    start = 1'b1;
    a     = 8'h12;
    b     = 8'h13;
    sm    = 1'b0;
    dones = 0;
    lat   = 0;
    @(negedge clk);
    while (!done && lat < 20) begin
      if (lat == 1) begin
        a = 8'hFF;
        b = 8'h00;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    res   = {gt, eq, lt};
    for (int i = 0; i < 6; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("hold lat",   lat, 4);
    check("hold res",   int'(res), int'(R_LT));
    check("hold dones", dones, 1);
    check("hold idle",  int'(busy), 0);

    // Reset two cycles into a compare aborts it.
    start = 1'b1;
    a     = 8'h12;
    b     = 8'h13;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort busy pre", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort res",  int'({gt, eq, lt}), int'(R_NONE));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    bc    = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) bc++;
    end
    check("abort no done", dones, 0);
    check("abort no busy", bc, 0);

`ifdef MAGCOMP_SIGNED_MODE_EN
    run_cmp(8'h80, 8'h01, 1'b1, lat, res, bc, zd);
    check("sgn1 lat", lat, 1);
    check("sgn1 res", int'(res), int'(R_LT));
    @(negedge clk);
    run_cmp(8'h80, 8'h01, 1'b0, lat, res, bc, zd);
    check("sgn0 lat", lat, 1);
    check("sgn0 res", int'(res), int'(R_GT));
    @(negedge clk);
    run_cmp(8'hFF, 8'hFE, 1'b1, lat, res, bc, zd);
    check("sgnff lat", lat, 4);
    check("sgnff res", int'(res), int'(R_GT));
    @(negedge clk);
`endif

    // WIDTH=16 sweep over DIGIT = 1, 4, 16.
    run_sweep(16'h8000, 16'h7FFF, "sw msb");
    run_sweep(16'h1234, 16'h1235, "sw lsb");
    run_sweep(16'hBEEF, 16'hBEEF, "sw eq");
    run_sweep(16'h0F00, 16'h0E00, "sw mid");
    run_sweep(16'h00A0, 16'h0100, "sw lt");
    run_sweep(16'h3C5A, 16'h3C4B, "sw nib");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/magnitude_comp_seq.md
Name: magnitude_comp_seq

Overview:
- Parametrised sequential magnitude comparator for WIDTH-bit operands.
- Compares DIGIT bits per cycle, MSB chunk first, and stops at the first unequal chunk.
- Start/busy/done handshake; the one-hot gt/eq/lt result is registered and held.
- Serves as the area-lean, multi-width successor to the team's single-cycle 2-bit comparator, for use where operands exceed combinational-compare timing budgets.

Parameters:
- WIDTH, 8, operand width in bits; must be at least 2.
- DIGIT, 2, bits compared per cycle; must be at least 1 and divide WIDTH exactly, otherwise elaboration fails. N = WIDTH/DIGIT chunks.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a compare; accepted only while idle
- a  input  WIDTH  operand A; sampled on the accepted start edge
- b  input  WIDTH  operand B; sampled on the accepted start edge
- busy  output  1  compare in progress
- done  output  1  one-cycle pulse; result valid from this cycle
- gt  output  1  A > B
- eq  output  1  A == B
- lt  output  1  A < B

Behaviour:
- Reset (async assert on rst_n low, deasserted synchronously by design): state=IDLE, busy=0, done=0, gt=0, eq=0, lt=0, chunk index=0, operand registers=0.
- States:
  - IDLE: busy=0. If start=1 at a clock edge: capture a and b, set index=N-1, clear gt/eq/lt to 0, go to RUN.
  - RUN: busy=1. Each edge compares chunk[index] of A and B, where a chunk is bits index*DIGIT+DIGIT-1 down to index*DIGIT.
    - Chunks differ: set gt or lt accordingly, pulse done, go to IDLE.
    - Chunks equal and index==0: set eq, pulse done, go to IDLE.
    - Otherwise: decrement index.
- Latency: k edges after the start edge, where k is the 1-based position of the first differing chunk counted from the MSB. k=N if the operands are equal or differ only in chunk 0. Range is 1..N cycles.
- done is registered: high for exactly one cycle, coincident with the first cycle gt/eq/lt are valid.
- Results:
  - gt/eq/lt are one-hot after done and held until the next accepted start.
  - They read all-zero from the accepted start edge until done.
- start while busy=1 is ignored; no queuing, no restart.
- Back-to-back: start=1 in the cycle done=1 is accepted, because the FSM is already IDLE. Results clear on that edge.
- Operand changes on a/b after the accepted start have no effect on the running compare.
- Reset mid-RUN aborts immediately: outputs return to reset values and no done is issued.
- DIGIT == WIDTH degenerates to a fixed 1-cycle compare; it must still obey the handshake.
- Index register width: max(1, clog2(N)).

Optional Feature:
- Macro: MAGCOMP_SIGNED_MODE_EN.
- Defined:
  - Adds input port signed_mode (1 bit), sampled with the operands on the accepted start edge.
  - When the captured signed_mode=1, operands are two's complement: the compare of chunk N-1 treats bit WIDTH-1 as a sign bit by inverting it on both operands before comparing. All other chunks compare unsigned, as normal.
  - When signed_mode=0, behaviour is identical to the macro-undefined build.
- Undefined: no signed_mode port; all compares are unsigned.

Test Plan (WIDTH=8, DIGIT=2 unless noted):
- MSB differs: a=0xA5, b=0x35, pulse start -> done after 1 cycle; gt=1, eq=0, lt=0; busy high for exactly 1 cycle.
- LSB differs / equal:
  - a=0x12, b=0x13 -> done after 4 cycles, lt=1.
  - a=b=0x5A -> done after 4 cycles, eq=1.
  - gt/eq/lt are 0 during busy in both cases.
- Handshake:
  - start held high through a 4-cycle compare, with a/b changed mid-run -> exactly one done; result reflects the captured values.
  - start in the done cycle with a=0x01, b=0x00 -> accepted; gt=1 after 4 cycles.
- Reset mid-operation: rst_n low two cycles after start of a=0x12, b=0x13 -> busy/done/gt/eq/lt immediately 0; no done pulse after release.
- Parameter sweep: WIDTH=16 with DIGIT=1, 4 and 16; random operand pairs -> result matches reference compare; latency equals the first-difference chunk position (max 16, 4 and 1 respectively).
- MAGCOMP_SIGNED_MODE_EN: a=0x80, b=0x01:
  - signed_mode=1 -> lt=1 after 1 cycle.
  - signed_mode=0 -> gt=1 after 1 cycle.
  - a=0xFF, b=0xFE with signed_mode=1 -> gt=1 after 4 cycles.
